// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: two-entry (main + skid) buffer between fetch and decode.
// Accepted instructions appear on id_* one cycle later. The immediate-type
// select is decoded at acceptance and stored with each entry.
// if_ready depends only on registered state, so there is no combinational
// path from id_ready back to fetch.
// Handshake: a transfer occurs on any rising edge where valid && ready are
// both 1. The offering side holds its payload stable while valid && !ready.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to add the id_illegal
// output and its per-entry storage.
// fsm_state exposes the occupancy state (0 EMPTY, 1 ONE, 2 TWO) for checkers.
module decode_issue_ctrl #(
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_inst,
   input  logic [PC_W-1:0] if_pc,
   input  logic            flush,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [31:0]     id_inst,
   output logic [PC_W-1:0] id_pc,
   output logic [2:0]      id_imm_type,
`ifdef DECODE_ILLEGAL_CHECK_EN
   output logic            id_illegal,
`endif
   output logic [1:0]      fsm_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t state;

   // Skid entry: holds the second instruction while main is stalled.
   logic [31:0]     skid_inst;
   logic [PC_W-1:0] skid_pc;
   logic [2:0]      skid_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
   logic            skid_illegal;
`endif

   logic acc;
   logic deq;
   logic [2:0] new_imm_type;

   // Immediate-type select from the major opcode; unlisted opcodes use 001.
   function automatic logic [2:0] imm_of(input logic [6:0] op);
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_of = 3'b000;
         7'b0100011:                                     imm_of = 3'b010;
         7'b1100011:                                     imm_of = 3'b011;
         7'b0110111, 7'b0010111:                         imm_of = 3'b100;
         7'b1101111:                                     imm_of = 3'b101;
         default:                                        imm_of = 3'b001;
      endcase
   endfunction

`ifdef DECODE_ILLEGAL_CHECK_EN
   // Illegal when not a 32-bit encoding or the opcode is not recognised.
   function automatic logic illegal_of(input logic [31:0] inst);
      logic known;
      case (inst[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011,
         7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
         7'b1101111, 7'b0110011: known = 1'b1;
         default:                known = 1'b0;
      endcase
      illegal_of = (inst[1:0] != 2'b11) || !known;
   endfunction

   logic new_illegal;
   // Illegal entries always carry immediate type 001.
   assign new_illegal  = illegal_of(if_inst);
   assign new_imm_type = new_illegal ? 3'b001 : imm_of(if_inst[6:0]);
`else
   assign new_imm_type = imm_of(if_inst[6:0]);
`endif

   assign if_ready  = (state != TWO);
   assign id_valid  = (state != EMPTY);
   assign acc       = if_valid && if_ready;
   assign deq       = id_valid && id_ready;
   assign fsm_state = state;

   // Occupancy FSM and entry storage; rst beats flush, flush beats accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         id_inst       <= '0;
         id_pc         <= '0;
         id_imm_type   <= '0;
         skid_inst     <= '0;
         skid_pc       <= '0;
         skid_imm_type <= '0;
`ifdef DECODE_ILLEGAL_CHECK_EN
         id_illegal    <= 1'b0;
         skid_illegal  <= 1'b0;
`endif
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state       <= ONE;
                  id_inst     <= if_inst;
                  id_pc       <= if_pc;
                  id_imm_type <= new_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
                  id_illegal  <= new_illegal;
`endif
               end
            end
            ONE: begin
               if (acc && deq) begin
                  // Replace main directly so the stream has no bubble.
                  id_inst     <= if_inst;
                  id_pc       <= if_pc;
                  id_imm_type <= new_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
                  id_illegal  <= new_illegal;
`endif
               end else if (acc) begin
                  state         <= TWO;
                  skid_inst     <= if_inst;
                  skid_pc       <= if_pc;
                  skid_imm_type <= new_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
                  skid_illegal  <= new_illegal;
`endif
               end else if (deq) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (deq) begin
                  state       <= ONE;
                  id_inst     <= skid_inst;
                  id_pc       <= skid_pc;
                  id_imm_type <= skid_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
                  id_illegal  <= skid_illegal;
`endif
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: reset, streaming, stall/skid,
// flush (alone and with accept), mid-run reset, and opcode decode.
module tb_decode_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [2:0]  id_imm_type;
`ifdef DECODE_ILLEGAL_CHECK_EN
   logic        id_illegal;
`endif
   logic [1:0]  fsm_state;

   int pass_cnt = 0;
   int total_cnt = 0;

   decode_issue_ctrl #(.PC_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_inst     (if_inst),
      .if_pc       (if_pc),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_inst     (id_inst),
      .id_pc       (id_pc),
      .id_imm_type (id_imm_type),
`ifdef DECODE_ILLEGAL_CHECK_EN
      .id_illegal  (id_illegal),
`endif
      .fsm_state   (fsm_state)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic offer(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      if_valid = v;
      if_inst  = inst;
      if_pc    = pc;
   endtask

   logic [31:0] str_inst [5];
   logic [2:0]  str_imm  [5];

   initial begin
      str_inst[0] = 32'h00500093; str_imm[0] = 3'b000;
      str_inst[1] = 32'h00112223; str_imm[1] = 3'b010;
      str_inst[2] = 32'hFE000EE3; str_imm[2] = 3'b011;
      str_inst[3] = 32'h000012B7; str_imm[3] = 3'b100;
      str_inst[4] = 32'h0080006F; str_imm[4] = 3'b101;

      // Reset
      rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      check("rst_id_valid", {31'b0, id_valid}, 32'd0);
      check("rst_if_ready", {31'b0, if_ready}, 32'd1);
      check("rst_imm_type", {29'b0, id_imm_type}, 32'd0);
      check("rst_id_inst", id_inst, 32'd0);
      check("rst_id_pc", id_pc, 32'd0);
      check("rst_state", {30'b0, fsm_state}, 32'd0);

      // Streaming with id_ready=1: each instruction one cycle later, no bubbles
      id_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         offer(1'b1, str_inst[i], 32'h100 + 32'(4 * i));
         tick();
         check($sformatf("str%0d_valid", i), {31'b0, id_valid}, 32'd1);
         check($sformatf("str%0d_inst", i), id_inst, str_inst[i]);
         check($sformatf("str%0d_pc", i), id_pc, 32'h100 + 32'(4 * i));
         check($sformatf("str%0d_imm", i), {29'b0, id_imm_type}, {29'b0, str_imm[i]});
         check($sformatf("str%0d_if_ready", i), {31'b0, if_ready}, 32'd1);
      end
      offer(1'b0, 32'h0, 32'h0);
      tick();
      check("str_drain_valid", {31'b0, id_valid}, 32'd0);

      // Stall: A and B accepted, C refused, A held stable
      id_ready = 1'b0;
      offer(1'b1, 32'h00000013, 32'h200);   // A: addi
      tick();
      check("stall_a_inst", id_inst, 32'h00000013);
      check("stall_a_if_ready", {31'b0, if_ready}, 32'd1);
      offer(1'b1, 32'h00002003, 32'h204);   // B: lw
      tick();
      check("stall_b_if_ready", {31'b0, if_ready}, 32'd0);
      check("stall_b_state", {30'b0, fsm_state}, 32'd2);
      check("stall_b_hold_inst", id_inst, 32'h00000013);
      offer(1'b1, 32'h00000033, 32'h208);   // C: add
      tick();
      tick();
      check("stall_c_hold_inst", id_inst, 32'h00000013);
      check("stall_c_hold_pc", id_pc, 32'h200);
      check("stall_c_hold_imm", {29'b0, id_imm_type}, 32'd0);
      check("stall_c_if_ready", {31'b0, if_ready}, 32'd0);
      id_ready = 1'b1;
      tick();                               // A leaves, B promoted from skid
      check("order_b_inst", id_inst, 32'h00002003);
      check("order_b_pc", id_pc, 32'h204);
      check("order_b_imm", {29'b0, id_imm_type}, 32'd0);
      check("order_b_if_ready", {31'b0, if_ready}, 32'd1);
      tick();                               // B leaves, C accepted in same cycle
      check("order_c_inst", id_inst, 32'h00000033);
      check("order_c_pc", id_pc, 32'h208);
      check("order_c_imm", {29'b0, id_imm_type}, 32'd1);
      check("order_c_valid", {31'b0, id_valid}, 32'd1);
      offer(1'b0, 32'h0, 32'h0);
      tick();
      check("order_drain_valid", {31'b0, id_valid}, 32'd0);

      // Flush in TWO with fetch offering
      id_ready = 1'b0;
      offer(1'b1, 32'h00100093, 32'h300);
      tick();
      offer(1'b1, 32'h00200113, 32'h304);
      tick();
      check("fl2_state", {30'b0, fsm_state}, 32'd2);
      flush = 1'b1;
      offer(1'b1, 32'h12345037, 32'h308);
      tick();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      check("fl2_valid", {31'b0, id_valid}, 32'd0);
      check("fl2_if_ready", {31'b0, if_ready}, 32'd1);
      id_ready = 1'b1;
      tick();
      check("fl2_no_ghost", {31'b0, id_valid}, 32'd0);

      // Flush coincident with accept in ONE: incoming dropped
      id_ready = 1'b0;
      offer(1'b1, 32'h00300193, 32'h400);
      tick();
      check("fl1_valid_before", {31'b0, id_valid}, 32'd1);
      flush = 1'b1;
      offer(1'b1, 32'h00400213, 32'h404);
      tick();
      flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      check("fl1_valid", {31'b0, id_valid}, 32'd0);
      tick();
      check("fl1_dropped", {31'b0, id_valid}, 32'd0);

      // Mid-run reset beats flush and accept
      offer(1'b1, 32'h00500293, 32'h500);
      tick();
      offer(1'b1, 32'h00600313, 32'h504);
      tick();
      rst = 1'b1; flush = 1'b1;
      offer(1'b1, 32'h00700393, 32'h508);
      tick();
      rst = 1'b0; flush = 1'b0;
      offer(1'b0, 32'h0, 32'h0);
      check("mrst_valid", {31'b0, id_valid}, 32'd0);
      check("mrst_if_ready", {31'b0, if_ready}, 32'd1);
      check("mrst_inst", id_inst, 32'd0);
      check("mrst_pc", id_pc, 32'd0);
      check("mrst_imm", {29'b0, id_imm_type}, 32'd0);

      // Opcode decode corner cases
      id_ready = 1'b1;
      offer(1'b1, 32'h00000000, 32'h600);
      tick();
      check("dec0_imm", {29'b0, id_imm_type}, 32'd1);
`ifdef DECODE_ILLEGAL_CHECK_EN
      check("dec0_illegal", {31'b0, id_illegal}, 32'd1);
`endif
      offer(1'b1, 32'h00000033, 32'h604);
      tick();
      check("dec33_imm", {29'b0, id_imm_type}, 32'd1);
`ifdef DECODE_ILLEGAL_CHECK_EN
      check("dec33_illegal", {31'b0, id_illegal}, 32'd0);
`endif
      offer(1'b1, 32'h00000073, 32'h608);   // system opcode
      tick();
      check("dec73_imm", {29'b0, id_imm_type}, 32'd0);
      offer(1'b1, 32'h00000017, 32'h60C);   // auipc
      tick();
      check("dec17_imm", {29'b0, id_imm_type}, 32'd4);
      offer(1'b1, 32'h00000067, 32'h610);   // jalr
      tick();
      check("dec67_imm", {29'b0, id_imm_type}, 32'd0);
      offer(1'b0, 32'h0, 32'h0);
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
